// File: rtl/ahb_bus_controller.sv
`default_nettype none
// ============================================================================
// Module  : ahb_bus_controller
// Purpose : Two-master round-robin AHB bus controller (IDLE/LOAD/ADDR/DATA)
//           with registered grant/select/enable outputs and DATA-phase timeout.
// Revision: 1.0 - initial release
// ============================================================================
module ahb_bus_controller #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req1,
  input  logic       req2,
  input  logic       wr1,
  input  logic       wr2,
  input  logic       rdyout,
  input  logic [1:0] respout,
  output logic       gnt1,
  output logic       gnt2,
  output logic       sel1,
  output logic       sel2,
  output logic       sel3,
  output logic       sel4,
  output logic       mux1,
  output logic       mux2,
  output logic       Aout,
  output logic       Dout,
  output logic       done1,
  output logic       done2,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ADDR = 2'd2,
    DATA = 2'd3
  } state_t;

  localparam logic [4:0] C_CNT_LAST = 5'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic       owner_q, owner_d;   // 0 = master 1, 1 = master 2
  logic       last_q, last_d;     // index of the master granted most recently
  logic       wr_q, wr_d;

  logic gnt1_q, gnt1_d, gnt2_q, gnt2_d;
  logic sel1_q, sel1_d, sel2_q, sel2_d, sel3_q, sel3_d, sel4_q, sel4_d;
  logic mux1_q, mux1_d, mux2_q, mux2_d;
  logic aout_q, aout_d, dout_q, dout_d;
  logic done1_q, done1_d, done2_q, done2_d, err_q, err_d;

  logic w_pick;

  // A tie goes to whichever master was not served last.
  assign w_pick = (req1 && req2) ? ~last_q : req2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      wr_q    <= 1'b0;
      gnt1_q  <= 1'b0;
      gnt2_q  <= 1'b0;
      sel1_q  <= 1'b0;
      sel2_q  <= 1'b0;
      sel3_q  <= 1'b0;
      sel4_q  <= 1'b0;
      mux1_q  <= 1'b0;
      mux2_q  <= 1'b0;
      aout_q  <= 1'b0;
      dout_q  <= 1'b0;
      done1_q <= 1'b0;
      done2_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
      gnt1_q  <= gnt1_d;
      gnt2_q  <= gnt2_d;
      sel1_q  <= sel1_d;
      sel2_q  <= sel2_d;
      sel3_q  <= sel3_d;
      sel4_q  <= sel4_d;
      mux1_q  <= mux1_d;
      mux2_q  <= mux2_d;
      aout_q  <= aout_d;
      dout_q  <= dout_d;
      done1_q <= done1_d;
      done2_q <= done2_d;
      err_q   <= err_d;
    end
  end

  // Outputs are decoded from the next state so they appear registered,
  // aligned with the state they describe.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    wr_d    = wr_q;
    gnt1_d  = 1'b0;
    gnt2_d  = 1'b0;
    sel1_d  = 1'b0;
    sel2_d  = 1'b0;
    sel3_d  = 1'b0;
    sel4_d  = 1'b0;
    mux1_d  = mux1_q;
    mux2_d  = mux2_q;
    aout_d  = 1'b0;
    dout_d  = 1'b0;
    done1_d = 1'b0;
    done2_d = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (req1 || req2) begin
          state_d = LOAD;
          owner_d = w_pick;
          last_d  = w_pick;
          wr_d    = w_pick ? wr2 : wr1;
          gnt1_d  = ~w_pick;
          gnt2_d  = w_pick;
          sel1_d  = ~w_pick;
          sel2_d  = w_pick;
          sel3_d  = ~w_pick & wr1;
          sel4_d  = w_pick & wr2;
          mux1_d  = w_pick;
          mux2_d  = w_pick;
        end
      end
      LOAD: begin
        state_d = ADDR;
        gnt1_d  = ~owner_q;
        gnt2_d  = owner_q;
        aout_d  = 1'b1;
      end
      ADDR: begin
        state_d = DATA;
        cnt_d   = 5'd0;
        gnt1_d  = ~owner_q;
        gnt2_d  = owner_q;
        aout_d  = 1'b1;
        dout_d  = wr_q;
      end
      DATA: begin
        if (rdyout) begin
          state_d = IDLE;
          if (respout == 2'b00) begin
            done1_d = ~owner_q;
            done2_d = owner_q;
          end else begin
            err_d = 1'b1;
          end
        end else if (cnt_q == C_CNT_LAST) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d  = cnt_q + 5'd1;
          gnt1_d = ~owner_q;
          gnt2_d = owner_q;
          aout_d = 1'b1;
          dout_d = wr_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign gnt1  = gnt1_q;
  assign gnt2  = gnt2_q;
  assign sel1  = sel1_q;
  assign sel2  = sel2_q;
  assign sel3  = sel3_q;
  assign sel4  = sel4_q;
  assign mux1  = mux1_q;
  assign mux2  = mux2_q;
  assign Aout  = aout_q;
  assign Dout  = dout_q;
  assign done1 = done1_q;
  assign done2 = done2_q;
  assign err   = err_q;

endmodule
`default_nettype wire
